// File: rtl/operand_pingpong_buffer.sv
// Double-buffered operand store for the systolic matmul core.
// A streaming loader fills the write bank with a weight matrix followed by an
// input matrix. The compute array reads the other bank through flat buses.
// Banks change roles on explicit handshakes (bank full / consumer release).
module operand_pingpong_buffer #(
    parameter int DATA_W = 8,
    parameter int DIM    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [DATA_W-1:0]           in_data_i,
    input  logic                        load_abort_i,
    output logic                        load_done_o,
    output logic [$clog2(2*DIM*DIM+1)-1:0] wr_count_o,
    output logic                        rd_valid_o,
    input  logic                        rd_release_i,
    output logic [DATA_W*DIM*DIM-1:0]   weights_flat_o,
    output logic [DATA_W*DIM*DIM-1:0]   inputs_flat_o
);

    localparam int MAT   = DIM * DIM;
    localparam int ELEMS = 2 * MAT;
    localparam int PTR_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int CNT_W = $clog2(ELEMS + 1);

    // Storage and control state
    logic [DATA_W-1:0] mem_q [2][ELEMS];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic              load_done_q, load_done_d;

    // Handshake qualifiers
    logic              in_ready_s;
    logic              accept_s;
    logic              last_s;
    logic              release_s;
    logic              rd_valid_s;

    assign in_ready_s = ~bank_full_q[wr_bank_q];
    // Abort wins over a same-cycle write so a discarded stream never lands.
    assign accept_s   = in_valid_i & in_ready_s & ~load_abort_i;
    assign last_s     = (wr_ptr_q == PTR_W'(ELEMS - 1));
    assign rd_valid_s = bank_full_q[rd_bank_q];
    assign release_s  = rd_release_i & rd_valid_s;

    assign in_ready_o  = in_ready_s;
    assign rd_valid_o  = rd_valid_s;
    assign load_done_o = load_done_q;
    assign wr_count_o  = CNT_W'(wr_ptr_q);

    // Next-state for pointers, bank roles, full flags and the done pulse.
    // Final accept and release touch different full bits (write bank is never
    // full while accepting, read bank is always full while releasing).
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        load_done_d = 1'b0;
        if (load_abort_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
        end else if (accept_s) begin
            if (last_s) begin
                wr_ptr_d               = {PTR_W{1'b0}};
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
                load_done_d            = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (release_s) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end else begin
            rd_bank_d = rd_bank_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
            load_done_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
            load_done_q <= load_done_d;
        end
    end

    // Operand storage; released banks keep their data until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < ELEMS; e++) begin
                    mem_q[b][e] <= {DATA_W{1'b0}};
                end
            end
        end else if (accept_s) begin
            mem_q[wr_bank_q][wr_ptr_q] <= in_data_i;
        end
    end

    // Zero-latency view of the read bank, row-major, independent of rd_valid.
    always_comb begin
        weights_flat_o = {(DATA_W*MAT){1'b0}};
        inputs_flat_o  = {(DATA_W*MAT){1'b0}};
        for (int j = 0; j < MAT; j++) begin
            weights_flat_o[j*DATA_W +: DATA_W] = mem_q[rd_bank_q][j];
            inputs_flat_o[j*DATA_W +: DATA_W]  = mem_q[rd_bank_q][MAT + j];
        end
    end

endmodule

// File: tb/tb_operand_pingpong_buffer.sv
// Directed bench for operand_pingpong_buffer (DIM=2, DATA_W=8, ELEMS=8).
// Completed bank images are queued as they are streamed in and compared when
// they appear on the read side.
module tb_operand_pingpong_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        load_abort;
    logic        load_done;
    logic [3:0]  wr_count;
    logic        rd_valid;
    logic        rd_release;
    logic [31:0] weights_flat;
    logic [31:0] inputs_flat;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [63:0] sb_q[$];
    logic [63:0] model_img = 64'h0;
    int          model_ptr = 0;
    logic [63:0] last_read = 64'h0;

    operand_pingpong_buffer #(.DATA_W(8), .DIM(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .load_abort_i   (load_abort),
        .load_done_o    (load_done),
        .wr_count_o     (wr_count),
        .rd_valid_o     (rd_valid),
        .rd_release_i   (rd_release),
        .weights_flat_o (weights_flat),
        .inputs_flat_o  (inputs_flat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one element, wait (bounded) for in_ready, optionally release in the accept cycle.
    task automatic send(input logic [7:0] d, input logic rel);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (in_ready) begin
            rd_release = rel;
            tick();
            model_img[model_ptr*8 +: 8] = d;
            model_ptr++;
            if (model_ptr == 8) begin
                sb_q.push_back(model_img);
                model_ptr = 0;
            end
        end else begin
            chk("send_ready_timeout", {63'h0, in_ready}, 64'h1);
        end
        in_valid   = 1'b0;
        rd_release = 1'b0;
    endtask

    // Compare the read side against the oldest completed image.
    task automatic check_read(input string tag);
        logic [63:0] e;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
        last_read = e;
        chk({tag, "_rd_valid"}, {63'h0, rd_valid}, 64'h1);
        chk({tag, "_weights"}, {32'h0, weights_flat}, {32'h0, e[31:0]});
        chk({tag, "_inputs"},  {32'h0, inputs_flat},  {32'h0, e[63:32]});
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"},  {63'h0, in_ready},  64'h1);
        chk({tag, "_load_done"}, {63'h0, load_done}, 64'h0);
        chk({tag, "_wr_count"},  {60'h0, wr_count},  64'h0);
        chk({tag, "_rd_valid"},  {63'h0, rd_valid},  64'h0);
        chk({tag, "_flats"},     {inputs_flat, weights_flat}, 64'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        load_abort = 1'b0;
        rd_release = 1'b0;
        #1;
        check_idle("reset");
        #21;
        rst_n = 1'b1;
        tick();

        // 1: first bank, done pulse and read view
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        chk("t1_load_done", {63'h0, load_done}, 64'h1);
        chk("t1_wr_count", {60'h0, wr_count}, 64'h0);
        check_read("t1");
        chk("t1_weights_const", {32'h0, weights_flat}, 64'h04030201);
        chk("t1_inputs_const", {32'h0, inputs_flat}, 64'h08070605);
        tick();
        chk("t1_load_done_drop", {63'h0, load_done}, 64'h0);

        // 2: second bank fills, then both full blocks the loader
        for (int i = 9; i <= 16; i++) send(8'(i), 1'b0);
        chk("t2_load_done", {63'h0, load_done}, 64'h1);
        in_valid = 1'b1;
        in_data  = 8'd17;
        chk("t2_in_ready_blocked", {63'h0, in_ready}, 64'h0);
        tick();
        tick();
        chk("t2_wr_count", {60'h0, wr_count}, 64'h0);
        chk("t2_hold_view", {inputs_flat, weights_flat}, last_read);

        // 3: release bank0, bank1 becomes visible, held 17 goes in
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        check_read("t3");
        chk("t3_weights_const", {32'h0, weights_flat}, 64'h0C0B0A09);
        chk("t3_in_ready", {63'h0, in_ready}, 64'h1);
        send(8'd17, 1'b0);
        chk("t3_wr_count", {60'h0, wr_count}, 64'h1);

        // 4: partial stream then abort with a same-cycle write
        send(8'd18, 1'b0);
        send(8'd19, 1'b0);
        send(8'd20, 1'b0);
        chk("t4_wr_count_pre", {60'h0, wr_count}, 64'h4);
        in_valid   = 1'b1;
        in_data    = 8'hEE;
        load_abort = 1'b1;
        tick();
        in_valid   = 1'b0;
        load_abort = 1'b0;
        model_ptr  = 0;
        chk("t4_wr_count_abort", {60'h0, wr_count}, 64'h0);
        chk("t4_still_reading", {63'h0, rd_valid}, 64'h1);
        for (int i = 0; i < 7; i++) send(8'(8'h21 + i), 1'b0);

        // 5: final accept coincides with release
        send(8'h28, 1'b1);
        chk("t5_load_done", {63'h0, load_done}, 64'h1);
        check_read("t5");
        chk("t5_in_ready", {63'h0, in_ready}, 64'h1);
        send(8'h31, 1'b0);
        chk("t5_wr_count", {60'h0, wr_count}, 64'h1);

        // 6: reset mid-stream with one bank full
        for (int i = 0; i < 4; i++) send(8'(8'h32 + i), 1'b0);
        chk("t6_wr_count_pre", {60'h0, wr_count}, 64'h5);
        chk("t6_sb_drained", 64'(sb_q.size()), 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("t6_async");
        #3;
        rst_n     = 1'b1;
        model_ptr = 0;
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        check_idle("t6_release_ignored");

        // Fresh load after reset with pseudo-random data
        for (int i = 0; i < 8; i++) send(8'($urandom_range(255, 0)), 1'b0);
        check_read("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
